// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        DONE,
        GUARD
    } spi_state_t;

    localparam int SPI_BITS  = 8;
    localparam int SPI_CNT_W = 4;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        gnt = '0;
        idx = '0;
        // k runs 1..N_REQ so ptr itself is considered last
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// One SPI mode-0 byte transmitter shared round-robin between N_REQ requesters,
// each with its own slave select. Outputs are registered decodes of the next state.
module spi_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int GUARD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic                 sck,
    output logic                 mosi,
    output logic [N_REQ-1:0]     ss_n
);
    import spi_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GRD_W = $clog2(GUARD + 1);

    spi_state_t           state_q, state_d;
    logic [SPI_BITS-1:0]  shift_q, shift_d;
    logic [SPI_CNT_W-1:0] cnt_q, cnt_d;
    logic [GRD_W-1:0]     grd_q, grd_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic [N_REQ-1:0]     ss_n_q, ss_n_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 xfer;

    logic                 arb_any;
    logic [N_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]     arb_idx;

    spi_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .any (arb_any),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        grd_d   = grd_q;
        g_d     = g_q;
        ptr_d   = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    g_d     = arb_idx;
                    shift_d = req_data[8*arb_idx +: SPI_BITS];
                    ptr_d   = arb_idx;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = SCK_HIGH;
            SCK_HIGH: begin
                shift_d = {shift_q[SPI_BITS-2:0], 1'b0};
                cnt_d   = cnt_q + SPI_CNT_W'(1);
                state_d = SCK_LOW;
            end
            SCK_LOW: begin
                if (cnt_q == SPI_CNT_W'(SPI_BITS)) state_d = DONE;
                else                               state_d = SCK_HIGH;
            end
            DONE: begin
                grd_d   = GRD_W'(GUARD);
                state_d = spi_pkg::GUARD;
            end
            spi_pkg::GUARD: begin
                if (grd_q <= GRD_W'(1)) state_d = IDLE;
                else                    grd_d   = grd_q - GRD_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they register in step with it
        xfer   = (state_d == SETUP) || (state_d == SCK_HIGH) || (state_d == SCK_LOW);
        sck_d  = (state_d == SCK_HIGH);
        mosi_d = xfer ? shift_d[SPI_BITS-1] : 1'b0;
        ss_n_d = '1;
        if (xfer) ss_n_d[g_d] = 1'b0;
        ack_d  = '0;
        if (state_d == DONE) ack_d[g_d] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grd_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= '1;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grd_q   <= grd_d;
            ptr_q   <= ptr_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        g_q     <= g_d;
    end

    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;
    assign ack  = ack_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomised scoreboard bench for spi_tx_arbiter (4 requesters) plus a 2-requester instance.
module tb_spi_tx_arbiter;

    localparam int NR = 4;
    localparam int G4 = 2;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req4;
    logic [8*NR-1:0] rd4;
    logic [NR-1:0] ack4;
    logic          busy4, sck4, mosi4;
    logic [NR-1:0] ss4;

    logic [1:0]    req2;
    logic [15:0]   rd2;
    logic [1:0]    ack2;
    logic          busy2, sck2, mosi2;
    logic [1:0]    ss2;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_ptr = NR - 1;
    exp_t exp_q[$];
    int   ack_t[$];
    logic [7:0] lane_q[NR][$];

    spi_tx_arbiter #(.N_REQ(NR), .GUARD(G4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_data(rd4), .ack(ack4),
        .busy(busy4), .sck(sck4), .mosi(mosi4), .ss_n(ss4)
    );

    spi_tx_arbiter #(.N_REQ(2), .GUARD(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_data(rd2), .ack(ack2),
        .busy(busy2), .sck(sck2), .mosi(mosi2), .ss_n(ss2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reconstruct each transfer from the pins and compare at ack against the scoreboard.
    initial begin : monitor
        int low_len, nb, cur_idx, a_idx;
        logic [7:0] bits;
        logic prev_sck, prev_ss_high;
        exp_t e;
        low_len = 0; nb = 0; cur_idx = 0; a_idx = 0; bits = 0;
        prev_sck = 0; prev_ss_high = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sck = 0;
            end else begin
                chk("ss_single", ($countones(~ss4) <= 1) ? 1 : 0, 1);
                chk("sck_without_ss", (sck4 && ss4 == '1) ? 1 : 0, 0);
                if (ss4 != '1) begin
                    if (prev_ss_high) begin
                        low_len = 0; nb = 0; bits = 0;
                        for (int i = 0; i < NR; i++) if (!ss4[i]) cur_idx = i;
                    end
                    low_len++;
                    if (sck4 && !prev_sck) begin
                        bits = {bits[6:0], mosi4};
                        nb++;
                    end
                end
                if (ack4 != '0) begin
                    a_idx = 0;
                    for (int i = 0; i < NR; i++) if (ack4[i]) a_idx = i;
                    ack_t.push_back(cyc);
                    chk("ack_onehot", $countones(ack4), 1);
                    chk("ack_ss_high", (ss4 == '1) ? 1 : 0, 1);
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", a_idx, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_idx", a_idx, e.idx);
                        chk("ss_idx", cur_idx, e.idx);
                        chk("byte", bits, e.data);
                        chk("nbits", nb, 8);
                        chk("ss_low_len", low_len, 17);
                    end
                end
                prev_sck = sck4;
            end
            prev_ss_high = (ss4 == '1);
        end
    end

    // Reference: all lanes pending at once; each grant goes to the next pending lane after the last grant.
    task automatic model_batch();
        int cnt[NR];
        int pos[NR];
        int left;
        left = 0;
        for (int i = 0; i < NR; i++) begin
            cnt[i] = lane_q[i].size();
            pos[i] = 0;
            left  += cnt[i];
        end
        while (left > 0) begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (cnt[i] > 0) begin
                    exp_q.push_back('{i, lane_q[i][pos[i]]});
                    pos[i]++;
                    cnt[i]--;
                    left--;
                    m_ptr = i;
                    break;
                end
            end
        end
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < NR; i++) begin
            req4[i] = (lane_q[i].size() > 0);
            rd4[8*i +: 8] = (lane_q[i].size() > 0) ? lane_q[i][0] : 8'($urandom);
        end
    endtask

    task automatic run_batch();
        int total, budget;
        logic empty;
        total = 0;
        for (int i = 0; i < NR; i++) total += lane_q[i].size();
        model_batch();
        budget = total * (19 + G4) + 20;
        drive_lanes();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (ack4[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
            drive_lanes();
            empty = 1;
            for (int i = 0; i < NR; i++) if (lane_q[i].size() > 0) empty = 0;
            if (empty && !busy4) break;
            budget--;
            if (budget <= 0) begin
                chk("batch_timeout", 0, 1);
                for (int i = 0; i < NR; i++) lane_q[i].delete();
                drive_lanes();
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1;
        req4 = '0;
        req2 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sck", sck4, 0);
        chk("rst_mosi", mosi4, 0);
        chk("rst_ss", ss4, 4'hF);
        chk("rst_ack", ack4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_ss2", ss2, 2'b11);
        rst   = 0;
        m_ptr = NR - 1;
        exp_q.delete();
    endtask

    initial begin : main
        logic [7:0] d;
        int b;
        rst = 1; req4 = '0; rd4 = '0; req2 = '0; rd2 = '0;
        do_reset();

        // Single 0xA5 transfer with a cycle-accurate pin table
        d = 8'hA5;
        exp_q.push_back('{0, d});
        m_ptr = 0;
        req4 = 4'b0001;
        rd4[7:0] = d;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            b = 7 - (k - 1) / 2;
            chk("t1_ss", ss4, (k <= 17) ? 4'b1110 : 4'b1111);
            chk("t1_ack", ack4, (k == 18) ? 4'b0001 : 4'b0000);
            chk("t1_busy", busy4, (k <= 20) ? 1 : 0);
            chk("t1_sck", sck4, (k >= 2 && k <= 16 && k % 2 == 0) ? 1 : 0);
            chk("t1_mosi", mosi4, (k <= 17 && b >= 0) ? int'(d[b]) : 0);
            if (k == 18) req4 = '0;
        end

        // All four at once after reset, distinct bytes
        do_reset();
        ack_t.delete();
        lane_q[0].push_back(8'h01);
        lane_q[1].push_back(8'h02);
        lane_q[2].push_back(8'h04);
        lane_q[3].push_back(8'h08);
        run_batch();
        chk("t2_acks", ack_t.size(), 4);
        for (int i = 1; i < ack_t.size(); i++) chk("t2_period", ack_t[i] - ack_t[i-1], 19 + G4);

        // Two requesters re-asserting after every ack alternate
        for (int n = 0; n < 3; n++) begin
            lane_q[0].push_back(8'($urandom));
            lane_q[2].push_back(8'($urandom));
        end
        run_batch();

        // Random batches
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NR; i++) begin
                int c;
                c = $urandom_range(0, 3);
                for (int n = 0; n < c; n++) lane_q[i].push_back(8'($urandom));
            end
            run_batch();
        end

        // Reset cuts a 0xFF transfer at cycle 9
        req4 = 4'b0001;
        rd4[7:0] = 8'hFF;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 9) begin
                rst  = 1;
                req4 = '0;
            end
            if (k == 10) begin
                chk("t4_sck", sck4, 0);
                chk("t4_mosi", mosi4, 0);
                chk("t4_ss", ss4, 4'hF);
                chk("t4_busy", busy4, 0);
                chk("t4_ack", ack4, 0);
                rst   = 0;
                m_ptr = NR - 1;
            end
        end
        lane_q[0].push_back(8'h3A);
        lane_q[1].push_back(8'hC5);
        run_batch();

        // Withdrawn request and changed data mid-transfer
        exp_q.push_back('{1, 8'h81});
        m_ptr = 1;
        req4 = 4'b0010;
        rd4[15:8] = 8'h81;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 5) begin
                req4 = '0;
                rd4[15:8] = 8'h00;
            end
            if (k >= 17 && k <= 19) chk("t5_ack", ack4, (k == 18) ? 4'b0010 : 4'b0000);
        end

        // Two-requester instance, GUARD=1, req[1] held continuously
        begin
            int acks[$];
            int hi_run, nb2, errs0;
            logic seen_low, psck;
            logic [7:0] b2;
            hi_run = 0; nb2 = 0; errs0 = 0; seen_low = 0; psck = 0; b2 = 0;
            req2 = 2'b10;
            rd2  = {8'h3C, 8'h00};
            for (int k = 1; k <= 70; k++) begin
                @(negedge clk);
                if (!ss2[0]) errs0++;
                if (!ss2[1]) begin
                    if (hi_run > 0 && seen_low) chk("t6_gap", hi_run, 3);
                    seen_low = 1;
                    hi_run   = 0;
                    if (sck2 && !psck) begin
                        b2 = {b2[6:0], mosi2};
                        nb2++;
                    end
                end else begin
                    hi_run++;
                end
                if (ack2 != 2'b00) begin
                    acks.push_back(k);
                    chk("t6_ack", ack2, 2'b10);
                    chk("t6_byte", b2, 8'h3C);
                    chk("t6_nbits", nb2, 8);
                    b2 = 0;
                    nb2 = 0;
                end
                psck = sck2;
            end
            req2 = '0;
            chk("t6_acks", (acks.size() >= 3) ? 1 : 0, 1);
            if (acks.size() > 0) chk("t6_first_ack", acks[0], 18);
            for (int i = 1; i < acks.size(); i++) chk("t6_period", acks[i] - acks[i-1], 20);
            chk("t6_ss0_low", errs0, 0);
        end

        repeat (5) @(negedge clk);
        chk("pending_expected", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
